exec_ctrl_alu: RTL and testbench
================================

# exec_ctrl_alu

- Registered execute/control stage for the RV32I single-cycle core.
- Decodes the 32-bit instruction into main control signals, a 2-bit ALU op class and a 4-bit ALU operation code.
- Applies that operation to two 32-bit operands.
- All outputs are registered, one cycle after the inputs.
- Sits between the decoder/register file and memory/writeback. Operand selection (register vs. immediate) is done outside the block.

## Interface
- No parameters. Data width is fixed at 32 bits.
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  reset, asynchronous and active-low.
- instruction  in  32  raw instruction. Fields used: opcode [6:0], funct3 [14:12], funct7 [31:25].
- src_a  in  32  ALU operand A.
- src_b  in  32  ALU operand B, already muxed by the caller.
- branch, memread, memtoreg, memwrite, alusrc, regwrite  out  1 each  main control signals.
- alu_op  out  2  ALU op class: 00 add, 01 branch, 10 R-type, 11 I-type arithmetic.
- alu_control  out  4  ALU operation code.
- result  out  32  ALU result.
- is_zero  out  1  high when result == 0.

## Operation
Main control from the opcode, listed as branch/memread/memtoreg/memwrite/alusrc/regwrite, alu_op:
- 0110011 (R): 0/0/0/0/0/1, 10
- 0010011 (I-ALU): 0/0/0/0/1/1, 11
- 0000011 (load): 0/1/1/0/1/1, 00
- 0100011 (store): 0/0/0/1/1/0, 00
- 1100011 (branch): 1/0/0/0/0/0, 01
- Any other opcode, including 0: all signals 0, alu_op 00.

alu_control codes:
- AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111.
- SLL 1000, SRL 1001, SRA 1010, SLTU 1011.

ALU controller:
- alu_op 00 → ADD.
- alu_op 01 → SUB (for BEQ compare).
- alu_op 10, by funct3:
  - 000: ADD, or SUB if funct7[5]=1
  - 001: SLL; 010: SLT; 011: SLTU; 100: XOR
  - 101: SRL, or SRA if funct7[5]=1
  - 110: OR; 111: AND
- alu_op 11: same as 10, except funct3 000 is always ADD. For 101, instruction[30] selects SRA.

ALU arithmetic:
- ADD/SUB: 32-bit modulo, overflow ignored.
- SLT: signed compare; SLTU: unsigned compare. Both give 1 or 0.
- Shifts: amount is src_b[4:0]. SRA sign-fills.
- Undefined alu_control codes give result 0.
- is_zero is derived from the same-cycle combinational result.

## Timing
- All outputs are flops. Each rising clk captures the decode and ALU values of the current inputs, so latency is exactly 1 cycle.
- The block is fully pipelined: new inputs every cycle, no handshake, no stall.
- While rstn=0: every output is forced to 0 asynchronously, including is_zero=0 and alu_control=0000.
- First capture is on the first rising edge after rstn deasserts. Deassertion is synchronized by the caller.
- Reset asserted mid-stream drops all pending values. No partial update is visible.
- Changes to X or Z on instruction bits outside opcode/funct3/funct7 have no effect.

## Structure
- Shared package `exec_pkg` holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH)
  - alu_op class constants
  - alu_control code constants
- One sub-module, `exec_alu_core`: combinational ALU taking src_a, src_b and alu_control, producing result and is_zero.
- Main decode, ALU-control decode and the output register live in the top module.

## Test plan
- Reset: hold rstn=0 with arbitrary inputs → all outputs 0. Release → first edge loads valid values.
- src_a=10, src_b=5, instruction=0x00000033 (ADD) → after 1 clk: result=15, is_zero=0, regwrite=1, alusrc=0, alu_op=10, alu_control=0010.
- Same operands, instruction=0x00000063 (BEQ) → result=5, branch=1, alu_op=01, alu_control=0110, regwrite=0. Then src_b=10 → is_zero=1.
- Same operands, instruction=0x00000023 (SW) → result=15, memwrite=1, alusrc=1, regwrite=0, memread=0.
- R-type SUB 0x40000033 with 10-5 → result=5.
- SRA 0x40005033 with src_a=0x80000000, src_b=4 → result=0xF8000000.
- SLT with src_a=0xFFFFFFFF, src_b=1 → result=1; SLTU with the same operands → result=0.
- Back-to-back: apply ADD, then SUB, then AND on consecutive cycles → results appear on consecutive cycles, each 1 cycle late. Opcode 0000000 → all control signals 0, alu_op 00, alu_control=0010.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared constants for the RV32I execute/control stage.
//   - opcode values of the instruction classes the stage decodes
//   - 2-bit ALU op class encoding
//   - 4-bit ALU operation codes
//   - packed struct holding the main control bundle
package exec_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;

    typedef struct packed {
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/exec_ctrl_alu_if.sv
// Bus bundle of the execute/control stage.
//   instruction/src_a/src_b : inputs from decode / register file
//   control, alu_op, alu_control, result, is_zero : registered outputs
// slave  : the stage itself
// master : the upstream/downstream side (driver of inputs, consumer of outputs)
interface exec_ctrl_alu_if;
    logic [31:0] instruction;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        branch;
    logic        memread;
    logic        memtoreg;
    logic        memwrite;
    logic        alusrc;
    logic        regwrite;
    logic [1:0]  alu_op;
    logic [3:0]  alu_control;
    logic [31:0] result;
    logic        is_zero;

    modport slave (
        input  instruction, src_a, src_b,
        output branch, memread, memtoreg, memwrite, alusrc, regwrite,
        output alu_op, alu_control, result, is_zero
    );

    modport master (
        output instruction, src_a, src_b,
        input  branch, memread, memtoreg, memwrite, alusrc, regwrite,
        input  alu_op, alu_control, result, is_zero
    );
endinterface

// File: rtl/exec_alu_core.sv
// Combinational 32-bit ALU.
//   src_a, src_b : operands (shift amount is src_b[4:0])
//   alu_control  : operation code
//   result       : operation result, 0 for undefined codes
//   is_zero      : result == 0
module exec_alu_core
    import exec_pkg::*;
(
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [3:0]  alu_control,
    output logic [31:0] result,
    output logic        is_zero
);

    logic [4:0] shamt;
    assign shamt = src_b[4:0];

    always_comb begin
        result = '0;
        case (alu_control)
            ALU_AND:  result = src_a & src_b;
            ALU_OR:   result = src_a | src_b;
            ALU_ADD:  result = src_a + src_b;
            ALU_XOR:  result = src_a ^ src_b;
            ALU_SUB:  result = src_a - src_b;
            ALU_SLT:  result = {31'd0, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: result = {31'd0, src_a < src_b};
            ALU_SLL:  result = src_a << shamt;
            ALU_SRL:  result = src_a >> shamt;
            ALU_SRA:  result = $unsigned($signed(src_a) >>> shamt);
            default:  result = '0;
        endcase
    end

    assign is_zero = (result == 32'd0);

endmodule

// File: rtl/exec_ctrl_alu.sv
// Registered execute/control stage of the RV32I core.
// Decodes opcode/funct3/funct7 into main control, ALU op class and ALU
// operation code, runs the ALU, and registers everything: latency 1 cycle,
// one new input set accepted every cycle.
//   clk   : rising-edge clock
//   rstn  : asynchronous active-low reset, clears all outputs
//   bus   : instruction/operands in, control + ALU result out
module exec_ctrl_alu
    import exec_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    exec_ctrl_alu_if.slave  bus
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;     // instruction[30] = funct7[5]: SUB / SRA select

    assign opcode = bus.instruction[6:0];
    assign funct3 = bus.instruction[14:12];
    assign alt    = bus.instruction[30];

    // Remaining instruction bits never reach any logic.
    logic unused_instr;
    assign unused_instr = ^{bus.instruction[31], bus.instruction[29:25],
                            bus.instruction[24:15], bus.instruction[11:7]};

    ctrl_t       ctrl_d, ctrl_q;
    logic [3:0]  alu_control_d, alu_control_q;
    logic [31:0] result_d, result_q;
    logic        is_zero_d, is_zero_q;

    // Main decode
    always_comb begin
        ctrl_d = '0;
        case (opcode)
            OP_R:      begin ctrl_d.regwrite = 1'b1; ctrl_d.alu_op = ALUOP_R; end
            OP_IMM:    begin ctrl_d.alusrc = 1'b1; ctrl_d.regwrite = 1'b1;
                             ctrl_d.alu_op = ALUOP_I; end
            OP_LOAD:   begin ctrl_d.memread = 1'b1; ctrl_d.memtoreg = 1'b1;
                             ctrl_d.alusrc = 1'b1; ctrl_d.regwrite = 1'b1;
                             ctrl_d.alu_op = ALUOP_ADD; end
            OP_STORE:  begin ctrl_d.memwrite = 1'b1; ctrl_d.alusrc = 1'b1;
                             ctrl_d.alu_op = ALUOP_ADD; end
            OP_BRANCH: begin ctrl_d.branch = 1'b1; ctrl_d.alu_op = ALUOP_BR; end
            default:   ctrl_d = '0;
        endcase
    end

    // ALU-control decode. Immediate forms have no SUBI, so funct3 000 stays
    // ADD there even when bit 30 happens to be set by the immediate.
    always_comb begin
        alu_control_d = ALU_ADD;
        case (ctrl_d.alu_op)
            ALUOP_ADD: alu_control_d = ALU_ADD;
            ALUOP_BR:  alu_control_d = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000: alu_control_d = (alt && ctrl_d.alu_op == ALUOP_R) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_control_d = ALU_SLL;
                    3'b010: alu_control_d = ALU_SLT;
                    3'b011: alu_control_d = ALU_SLTU;
                    3'b100: alu_control_d = ALU_XOR;
                    3'b101: alu_control_d = alt ? ALU_SRA : ALU_SRL;
                    3'b110: alu_control_d = ALU_OR;
                    default: alu_control_d = ALU_AND;
                endcase
            end
        endcase
    end

    exec_alu_core u_alu (
        .src_a       (bus.src_a),
        .src_b       (bus.src_b),
        .alu_control (alu_control_d),
        .result      (result_d),
        .is_zero     (is_zero_d)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_q        <= '0;
            alu_control_q <= '0;
            result_q      <= '0;
            is_zero_q     <= 1'b0;
        end else begin
            ctrl_q        <= ctrl_d;
            alu_control_q <= alu_control_d;
            result_q      <= result_d;
            is_zero_q     <= is_zero_d;
        end
    end

    assign bus.branch      = ctrl_q.branch;
    assign bus.memread     = ctrl_q.memread;
    assign bus.memtoreg    = ctrl_q.memtoreg;
    assign bus.memwrite    = ctrl_q.memwrite;
    assign bus.alusrc      = ctrl_q.alusrc;
    assign bus.regwrite    = ctrl_q.regwrite;
    assign bus.alu_op      = ctrl_q.alu_op;
    assign bus.alu_control = alu_control_q;
    assign bus.result      = result_q;
    assign bus.is_zero     = is_zero_q;

endmodule

// File: tb/tb_exec_ctrl_alu.sv
// Bench for exec_ctrl_alu: directed vectors, mid-stream reset and a
// randomized stream checked against a reference model.
module tb_exec_ctrl_alu;

    logic clk;
    logic rstn;
    exec_ctrl_alu_if bus ();

    exec_ctrl_alu dut (.clk(clk), .rstn(rstn), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [5:0]  ctl;     // branch,memread,memtoreg,memwrite,alusrc,regwrite
        logic [1:0]  op;
        logic [3:0]  code;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    // Reference: built straight from the instruction-set rules.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        logic [2:0] f3;
        logic alt;
        int sh;
        f3  = ins[14:12];
        alt = ins[30];
        sh  = int'(b[4:0]);
        case (ins[6:0])
            7'h33:   begin e.ctl = 6'b000001; e.op = 2'd2; end
            7'h13:   begin e.ctl = 6'b000011; e.op = 2'd3; end
            7'h03:   begin e.ctl = 6'b011011; e.op = 2'd0; end
            7'h23:   begin e.ctl = 6'b000110; e.op = 2'd0; end
            7'h63:   begin e.ctl = 6'b100000; e.op = 2'd1; end
            default: begin e.ctl = 6'b000000; e.op = 2'd0; end
        endcase
        if (e.op == 2'd0)      e.code = 4'd2;
        else if (e.op == 2'd1) e.code = 4'd6;
        else begin
            case (f3)
                3'd0: e.code = (e.op == 2'd2 && alt) ? 4'd6 : 4'd2;
                3'd1: e.code = 4'd8;
                3'd2: e.code = 4'd7;
                3'd3: e.code = 4'd11;
                3'd4: e.code = 4'd3;
                3'd5: e.code = alt ? 4'd10 : 4'd9;
                3'd6: e.code = 4'd1;
                default: e.code = 4'd0;
            endcase
        end
        case (e.code)
            4'd0:  e.res = a & b;
            4'd1:  e.res = a | b;
            4'd2:  e.res = a + b;
            4'd3:  e.res = a ^ b;
            4'd6:  e.res = a - b;
            4'd7:  e.res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd11: e.res = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            4'd8:  e.res = a << sh;
            4'd9:  e.res = a >> sh;
            4'd10: e.res = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            default: e.res = 32'd0;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    task automatic check_out(input string tag, input exp_t e);
        chk({tag, ".ctl"}, {26'd0, bus.branch, bus.memread, bus.memtoreg,
                            bus.memwrite, bus.alusrc, bus.regwrite}, {26'd0, e.ctl});
        chk({tag, ".alu_op"}, {30'd0, bus.alu_op}, {30'd0, e.op});
        chk({tag, ".alu_ctl"}, {28'd0, bus.alu_control}, {28'd0, e.code});
        chk({tag, ".result"}, bus.result, e.res);
        chk({tag, ".zero"}, {31'd0, bus.is_zero}, {31'd0, e.zero});
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.ctl = '0; e.op = '0; e.code = '0; e.res = '0; e.zero = 1'b0;
        return e;
    endfunction

    // Called at a negedge: drive, capture on posedge, check 1 ns later,
    // and return at the following negedge ready for the next vector.
    task automatic apply(input string tag, input logic [31:0] ins,
                         input logic [31:0] a, input logic [31:0] b);
        bus.instruction = ins;
        bus.src_a       = a;
        bus.src_b       = b;
        @(posedge clk);
        #1;
        check_out(tag, model(ins, a, b));
        @(negedge clk);
    endtask

    // Fields guaranteed not to matter get random fill.
    function automatic logic [31:0] rnd_instr();
        logic [31:0] ins;
        logic [6:0] opcs [6];
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h00};
        ins = $urandom;
        if ($urandom_range(0, 9) != 0) ins[6:0] = opcs[$urandom_range(0, 5)];
        if ($urandom_range(0, 1) != 0) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return ins;
    endfunction

    function automatic logic [31:0] rnd_data();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'(int'($urandom_range(0, 40)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rstn = 1'b0;
        bus.instruction = 32'h0000_0033;
        bus.src_a = 32'd10;
        bus.src_b = 32'd5;

        // Reset held with changing inputs: outputs stay 0
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.instruction = rnd_instr();
            bus.src_a = $urandom;
            bus.src_b = $urandom;
            @(posedge clk);
            #1;
            check_out("reset", zero_exp());
        end
        @(negedge clk);
        rstn = 1'b1;

        apply("add",   32'h0000_0033, 32'd10, 32'd5);
        apply("beq",   32'h0000_0063, 32'd10, 32'd5);
        apply("beq_eq",32'h0000_0063, 32'd10, 32'd10);
        chk("beq_eq.zero_lit", {31'd0, bus.is_zero}, 32'd1);
        apply("sw",    32'h0000_0023, 32'd10, 32'd5);
        chk("sw.result_lit", bus.result, 32'd15);
        apply("sub",   32'h4000_0033, 32'd10, 32'd5);
        chk("sub.result_lit", bus.result, 32'd5);
        apply("sra",   32'h4000_5033, 32'h8000_0000, 32'd4);
        chk("sra.result_lit", bus.result, 32'hF800_0000);
        apply("slt",   32'h0000_2033, 32'hFFFF_FFFF, 32'd1);
        chk("slt.result_lit", bus.result, 32'd1);
        apply("sltu",  32'h0000_3033, 32'hFFFF_FFFF, 32'd1);
        chk("sltu.result_lit", bus.result, 32'd0);
        apply("lw",    32'h0000_0003, 32'h100, 32'h4);
        apply("srai",  32'h4000_5013, 32'h8000_0000, 32'd8);
        apply("addi30",32'h4000_0013, 32'd10, 32'd5);
        apply("srli",  32'h0000_5013, 32'h8000_0000, 32'd31);

        // Back-to-back ADD, SUB, AND: each on its own consecutive cycle
        apply("b2b_add", 32'h0000_0033, 32'h0F0F_00FF, 32'h0FF0_0F01);
        apply("b2b_sub", 32'h4000_0033, 32'h0F0F_00FF, 32'h0FF0_0F01);
        apply("b2b_and", 32'h0000_7033, 32'h0F0F_00FF, 32'h0FF0_0F01);

        apply("op0",   32'h0000_0000, 32'd3, 32'd4);
        chk("op0.alu_ctl_lit", {28'd0, bus.alu_control}, 32'd2);

        // Mid-stream reset: outputs clear without waiting for an edge
        bus.instruction = 32'h0000_0033;
        bus.src_a = 32'd7;
        bus.src_b = 32'd8;
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_out("async_rst", zero_exp());
        @(posedge clk);
        #1;
        check_out("async_rst_hold", zero_exp());
        @(negedge clk);
        rstn = 1'b1;
        apply("post_rst", 32'h0000_6033, 32'hA0A0_0000, 32'h0000_0505);

        // Randomized stream
        for (int i = 0; i < 400; i++)
            apply("rnd", rnd_instr(), rnd_data(), rnd_data());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", checks, 0);
        $fatal(1, "timeout");
    end

endmodule
